// File: rtl/btn_pkg.sv
// Shared encodings for the push-button conditioner: debounce FSM states,
// button indices and the fixed press-event priority order.
package btn_pkg;

    localparam int NUM_BTN = 4;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_WARN  = 2;
    localparam int BTN_SAFE  = 3;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Highest priority first: safe always wins, warning always loses.
    localparam int PRIO_ORDER [NUM_BTN] = '{BTN_SAFE, BTN_LEFT, BTN_RIGHT, BTN_WARN};

    function automatic logic [NUM_BTN-1:0] prio_select(input logic [NUM_BTN-1:0] req);
        logic [NUM_BTN-1:0] grant;
        grant = '0;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (req[PRIO_ORDER[k]]) begin
                grant                = '0;
                grant[PRIO_ORDER[k]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/btn_conditioner_debounce.sv
// One-bit button conditioner: 2-flop synchronizer, press/release debounce
// FSM with a saturating stability counter, registered clean level.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 1250000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_clean,
    output logic o_accept
);

    localparam int CW = $clog2(DEBOUNCE_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    logic          r_sync1;
    logic          r_sync2;
    btn_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_clean;

    btn_state_e    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_accept;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            RELEASED: begin
                if (r_sync2) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_next = RELEASED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HELD;
                    w_accept     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high resumes HELD without a new event.
                if (r_sync2) begin
                    w_state_next = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = RELEASED;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = RELEASED;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_clean <= (r_state == HELD) || (r_state == RELEASE_WAIT);
        end
    end

    assign o_clean  = r_clean;
    assign o_accept = w_accept;

endmodule

// File: rtl/btn_conditioner.sv
// Four-button conditioner: per-bit debouncers feed a pending register that
// releases at most one press event per cycle in fixed priority order.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 1250000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_pending
);

    logic [NUM_BTN-1:0] w_clean;
    logic [NUM_BTN-1:0] w_accept;
    logic [NUM_BTN-1:0] w_grant;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] r_press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
        btn_debounce #(
            .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
        ) u_deb (
            .i_clk   (clk),
            .i_reset (reset),
            .i_raw   (btn_raw[i]),
            .o_clean (w_clean[i]),
            .o_accept(w_accept[i])
        );
    end

    assign w_grant = prio_select(r_pending);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_press   <= '0;
        end else begin
            r_press   <= w_grant;
            // OR-ing the new accepts after the clear lets a same-cycle set win.
            r_pending <= (r_pending & ~w_grant) | w_accept;
        end
    end

    assign btn_clean   = w_clean;
    assign btn_press   = r_press;
    assign btn_pending = r_pending;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_COUNT = 4: table of
// per-edge vectors plus hand-written latency sequences.
module tb_btn_conditioner;

  localparam int DC = 4;

  logic       clk;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] btn_clean;
  logic [3:0] btn_press;
  logic [3:0] btn_pending;

  int n_vec;
  int n_err;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] press;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];

  btn_conditioner #(
    .DEBOUNCE_COUNT(DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_clean  (btn_clean),
    .btn_press  (btn_press),
    .btn_pending(btn_pending)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic rst, input logic [3:0] raw, input logic [3:0] clean,
                              input logic [3:0] press, input logic [3:0] pend);
    vec_t v;
    v.rst   = rst;
    v.raw   = raw;
    v.clean = clean;
    v.press = press;
    v.pend  = pend;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst();
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic build_table();
    logic [3:0] p;
    logic [3:0] q;
    // 1: bit 0 held 20 cycles then released
    add_rst();
    for (int e = 1; e <= 30; e++)
      add(1'b0, (e <= 20) ? 4'b0001 : 4'b0000,
          (e >= 8 && e <= 27) ? 4'b0001 : 4'b0000,
          (e == 8) ? 4'b0001 : 4'b0000,
          (e == 7) ? 4'b0001 : 4'b0000);
    // 2: bit 1 bounces high 2, low 1, then high 20
    add_rst();
    for (int e = 1; e <= 23; e++)
      add(1'b0, (e <= 2 || e >= 4) ? 4'b0010 : 4'b0000,
          (e >= 11) ? 4'b0010 : 4'b0000,
          (e == 11) ? 4'b0010 : 4'b0000,
          (e == 10) ? 4'b0010 : 4'b0000);
    // 3: bit 2 short glitch of 3 cycles
    add_rst();
    for (int e = 1; e <= 13; e++)
      add(1'b0, (e <= 3) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // 4: bits 0 and 3 together
    add_rst();
    for (int e = 1; e <= 12; e++) begin
      p = (e == 8) ? 4'b1000 : (e == 9) ? 4'b0001 : 4'b0000;
      q = (e == 7) ? 4'b1001 : (e == 8) ? 4'b0001 : 4'b0000;
      add(1'b0, 4'b1001, (e >= 8) ? 4'b1001 : 4'b0000, p, q);
    end
    // 5: reset at edge 5 while bit 0 stays held
    add_rst();
    for (int e = 1; e <= 20; e++)
      add((e == 5) ? 1'b1 : 1'b0, 4'b0001,
          (e >= 13) ? 4'b0001 : 4'b0000,
          (e == 13) ? 4'b0001 : 4'b0000,
          (e == 12) ? 4'b0001 : 4'b0000);
    // 6: long hold, release 10, press again
    add_rst();
    for (int e = 1; e <= 75; e++)
      add(1'b0, (e <= 50 || e >= 61) ? 4'b0001 : 4'b0000,
          ((e >= 8 && e <= 57) || e >= 68) ? 4'b0001 : 4'b0000,
          (e == 8 || e == 68) ? 4'b0001 : 4'b0000,
          (e == 7 || e == 67) ? 4'b0001 : 4'b0000);
    // 7: all four at once, released in order safe, left, right, warning
    add_rst();
    for (int e = 1; e <= 14; e++) begin
      p = (e == 8) ? 4'b1000 : (e == 9) ? 4'b0001 : (e == 10) ? 4'b0010 :
          (e == 11) ? 4'b0100 : 4'b0000;
      q = (e == 7) ? 4'b1111 : (e == 8) ? 4'b0111 : (e == 9) ? 4'b0110 :
          (e == 10) ? 4'b0100 : 4'b0000;
      add(1'b0, 4'b1111, (e >= 8) ? 4'b1111 : 4'b0000, p, q);
    end
    // 8: bit 1 bounces low for 2 cycles during release debounce
    add_rst();
    for (int e = 1; e <= 30; e++)
      add(1'b0, (e <= 12 || e >= 15) ? 4'b0010 : 4'b0000,
          (e >= 8) ? 4'b0010 : 4'b0000,
          (e == 8) ? 4'b0010 : 4'b0000,
          (e == 7) ? 4'b0010 : 4'b0000);
  endtask

  // scoreboard / main test
  initial begin
    int lat;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    btn_raw = 4'b0000;
    build_table();

    foreach (vecs[i]) begin
      reset   = vecs[i].rst;
      btn_raw = vecs[i].raw;
      step();
      n_vec++;
      if (btn_clean !== vecs[i].clean || btn_press !== vecs[i].press ||
          btn_pending !== vecs[i].pend) begin
        n_err++;
        $display("FAIL vec%0d: clean=%b press=%b pending=%b, required clean=%b press=%b pending=%b",
                 i, btn_clean, btn_press, btn_pending, vecs[i].clean, vecs[i].press, vecs[i].pend);
      end
    end

    // bounded wait for a lone warning press
    reset   = 1'b1;
    btn_raw = 4'b0000;
    step();
    reset   = 1'b0;
    btn_raw = 4'b0100;
    lat     = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_press != 4'b0000) begin
        lat = k;
        break;
      end
    end
    check_val("warn_press_latency", lat, DC + 4);
    check_val("warn_press_value", int'(btn_press), 4);
    step();
    check_val("warn_press_single", int'(btn_press), 0);
    check_val("warn_clean_held", int'(btn_clean), 4);

    // bounded wait for the clean level to fall after release
    btn_raw = 4'b0000;
    lat     = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_clean == 4'b0000) begin
        lat = k;
        break;
      end
    end
    check_val("warn_release_latency", lat, DC + 4);
    check_val("warn_release_no_press", int'(btn_press), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-side companion to the road-sign mode FSM. Converts the four raw, bouncing PYNQ Z1 push-buttons into debounced levels and single-cycle, strictly one-hot press events: the form the mode FSM's button decoder accepts. Presses that arrive together are buffered and released one per cycle in a fixed priority order, so the downstream logic never sees a multi-hot event.

## Interface
- `DEBOUNCE_COUNT`, default 1250000: stable cycles required before a level change is accepted. This is 10 ms at 125 MHz; the bench uses 4. Must be ≥ 2.
- `clk`, input, 1: system clock (125 MHz).
- `reset`, input, 1: synchronous, active-high. Clears all state on the next `clk` edge.
- `btn_raw`, input, 4: asynchronous raw buttons. Bit 0 = left, 1 = right, 2 = warning, 3 = safe.
- `btn_clean`, output, 4: debounced button levels, registered.
- `btn_press`, output, 4: one-cycle press event, registered. Always zero or one-hot.
- `btn_pending`, output, 4: presses accepted but not yet emitted (debug/LED visibility).

## Operation
- Each bit has a 2-flop synchronizer (`sync1`, `sync2`). Both reset to 0.
- Each bit has a 4-state FSM plus a counter `cnt` of width `$clog2(DEBOUNCE_COUNT)`:
  - **RELEASED**: if `sync2` = 1, go to PRESS_WAIT and set `cnt` = 0.
  - **PRESS_WAIT**:
    - If `sync2` = 0, return to RELEASED.
    - Else if `cnt` = DEBOUNCE_COUNT−1, go to HELD and set that bit's pending flag.
    - Else increment `cnt`.
  - **HELD**: if `sync2` = 0, go to RELEASE_WAIT and set `cnt` = 0.
  - **RELEASE_WAIT**:
    - If `sync2` = 1, return to HELD. No new event is generated.
    - Else if `cnt` = DEBOUNCE_COUNT−1, go to RELEASED.
    - Else increment `cnt`.
- `btn_clean[i]` <= 1 when the FSM is in HELD or RELEASE_WAIT. The value is registered, so it tracks the FSM state one edge later.
- Holding a button never repeats the event. A new event requires a full release, then a full press.
- Pending register and emitter:
  - Each cycle, if `pending` ≠ 0, select the highest-priority set bit. Priority order is 3 > 0 > 1 > 2, so safe always wins.
  - Drive `btn_press` <= one-hot of the selected bit and clear that pending bit. Otherwise drive `btn_press` <= 0.
  - A set arriving in the same cycle as a clear of the same bit wins: the bit stays pending.
  - Re-pressing a bit that is still pending coalesces into one event.
- Reset:
  - Returns all FSMs to RELEASED and clears `cnt`, `pending`, both synchronizer stages and all outputs.
  - A button still physically held when reset is released is re-debounced and produces a fresh press.

## Timing
- All outputs are 0 at reset.
- Edges are counted from the first edge that samples a raw rise, called edge 1. With the raw input stable:
  - The FSM enters PRESS_WAIT at edge 3.
  - The FSM enters HELD at edge DEBOUNCE_COUNT+3.
  - `btn_clean` rises at edge DEBOUNCE_COUNT+4.
  - `btn_press` pulses for exactly one cycle at edge DEBOUNCE_COUNT+4, when there is no contention.
- Contention delays lower-priority events by one cycle per higher-priority event. No event is dropped.
- Release latency: `btn_clean` falls at edge DEBOUNCE_COUNT+4 after the raw fall.
- Any bounce inside a WAIT state restarts the count from the next stable sample.
- `cnt` never exceeds DEBOUNCE_COUNT−1. There is no wrap-around.

## Structure
- Shared package/header `btn_pkg` holds:
  - State encodings RELEASED = 2'd0, PRESS_WAIT = 2'd1, HELD = 2'd2, RELEASE_WAIT = 2'd3.
  - Button index constants BTN_LEFT = 0, BTN_RIGHT = 1, BTN_WARN = 2, BTN_SAFE = 3.
  - The priority order.
- Sub-module `btn_debounce`: synchronizer, FSM and counter for one bit. It outputs `clean` and a one-cycle `accept` strobe and is instantiated 4×.
- The top level holds only the pending register, the priority emitter and the output registers.

## Test plan
All scenarios use DEBOUNCE_COUNT = 4.
1. Raw bit 0 rises and is held 20 cycles -> `btn_clean[0]` = 1 from edge 8; `btn_press` = 0001 at edge 8 only; 0 at every other edge.
2. Raw bit 1 is high 2 cycles, low 1, then high 20 -> exactly one 0010 pulse, 8 edges after the final rise; `btn_clean[1]` never toggles during the bounce.
3. Raw bit 2 is high for 3 cycles only -> `btn_press` and `btn_clean` stay 0000.
4. Raw bits 0 and 3 rise in the same cycle -> 1000 at edge 8, 0001 at edge 9; `btn_pending` reads 0001 between them.
5. Reset asserted at edge 5 of a bit-0 press, raw still held -> all outputs 0 at edge 6; after reset deasserts, one 0001 pulse 8 edges later.
6. Bit 0 held 50 cycles -> one pulse only; release for 10 cycles, then press again -> a second 0001 pulse.
